// File: rtl/peripheral_pkg.sv
// Shared types and defaults for the operation calculator: opcode and FSM state
// encodings plus the default operand/opcode widths.
package peripheral_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_OPW   = 3;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_MUL = 3'd5,
        OP_DIV = 3'd6,
        OP_REM = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_ITER = 2'd2,
        S_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/peripheral_muldiv_iter.sv
// Bit-serial datapath: shift-add multiply (low WIDTH bits) and restoring divide.
// Outputs show the value after the current step, so the last step can be captured directly.
module peripheral_muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] product,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_rem;

    logic [WIDTH-1:0] w_acc_nxt;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_fits;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;

    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);

    // The partial remainder stays below the divisor, so WIDTH+1 bits hold the shifted value
    // and the top bit of the difference is a clean borrow flag.
    assign w_shift   = {r_rem, r_quo[WIDTH-1]};
    assign w_diff    = w_shift - {1'b0, r_div};
    assign w_fits    = ~w_diff[WIDTH];
    assign w_rem_nxt = w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quo_nxt = {r_quo[WIDTH-2:0], w_fits};

    assign product   = w_acc_nxt;
    assign quotient  = w_quo_nxt;
    assign remainder = w_rem_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_rem    <= '0;
        end else if (load) begin
            r_mcand  <= a;
            r_mplier <= b;
            r_acc    <= '0;
            r_quo    <= a;
            r_div    <= b;
            r_rem    <= '0;
        end else if (step) begin
            if (!mode) begin
                r_acc    <= w_acc_nxt;
                r_mcand  <= {r_mcand[WIDTH-2:0], 1'b0};
                r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
            end else begin
                r_rem <= w_rem_nxt;
                r_quo <= w_quo_nxt;
            end
        end
    end

endmodule

// File: rtl/peripheral_opcalc.sv
// Operation calculator: captures a request, runs a one-cycle ALU or the iterative
// multiply/divide unit, and reports result/error with a one-cycle done strobe.
module peripheral_opcalc
    import peripheral_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int OPW   = DEF_OPW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [OPW-1:0]   opsel,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [OPW-1:0]   r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_error;
    logic             r_busy;
    logic             r_done;

    logic             w_sel_iter;
    logic             w_last;
    logic             w_load;
    logic             w_step;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_mode;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_err;
    logic [WIDTH-1:0] w_iter_res;
    logic [WIDTH-1:0] w_product;
    logic [WIDTH-1:0] w_quotient;
    logic [WIDTH-1:0] w_remainder;

    assign w_sel_iter = (opsel == OPW'(OP_MUL)) ||
                        (((opsel == OPW'(OP_DIV)) || (opsel == OPW'(OP_REM))) && (dataB != '0));
    assign w_last     = (r_cnt == CW'(WIDTH - 1));
    assign w_mode     = (r_op != OPW'(OP_MUL));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = w_sel_iter ? S_ITER : S_CALC;
            S_CALC:  w_state_nxt = S_DONE;
            S_ITER:  if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_load     = (r_state == S_IDLE) && start;
        w_step     = (r_state == S_ITER);
        w_busy_nxt = (w_state_nxt == S_CALC) || (w_state_nxt == S_ITER);
        w_done_nxt = (w_state_nxt == S_DONE);
    end

    // Only faulted DIV/REM (B=0) reach CALC, so those branches produce the fault values.
    always_comb begin
        w_alu_res = '0;
        w_alu_err = 1'b0;
        if (32'(r_op) > 32'd7) begin
            w_alu_err = 1'b1;
        end else begin
            case (op_e'(r_op[2:0]))
                OP_ADD:  w_alu_res = r_a + r_b;
                OP_SUB:  w_alu_res = r_a - r_b;
                OP_AND:  w_alu_res = r_a & r_b;
                OP_OR:   w_alu_res = r_a | r_b;
                OP_XOR:  w_alu_res = r_a ^ r_b;
                OP_DIV: begin
                    w_alu_res = '1;
                    w_alu_err = 1'b1;
                end
                OP_REM: begin
                    w_alu_res = r_a;
                    w_alu_err = 1'b1;
                end
                default: w_alu_res = '0;
            endcase
        end
    end

    always_comb begin
        w_iter_res = w_product;
        if (r_op == OPW'(OP_DIV)) begin
            w_iter_res = w_quotient;
        end else if (r_op == OPW'(OP_REM)) begin
            w_iter_res = w_remainder;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_error  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
            if (w_load) begin
                r_op  <= opsel;
                r_a   <= dataA;
                r_b   <= dataB;
                r_cnt <= '0;
            end else if (r_state == S_ITER) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == S_CALC) begin
                r_result <= w_alu_res;
                r_error  <= w_alu_err;
            end else if ((r_state == S_ITER) && w_last) begin
                r_result <= w_iter_res;
                r_error  <= 1'b0;
            end
        end
    end

    peripheral_muldiv_iter #(
        .WIDTH(WIDTH)
    ) u_iter (
        .clk       (clk),
        .reset     (reset),
        .load      (w_load),
        .step      (w_step),
        .mode      (w_mode),
        .a         (dataA),
        .b         (dataB),
        .product   (w_product),
        .quotient  (w_quotient),
        .remainder (w_remainder)
    );

    assign result = r_result;
    assign busy   = r_busy;
    assign done   = r_done;
    assign error  = r_error;

endmodule

// File: tb/tb_peripheral_opcalc.sv
// Bench for peripheral_opcalc: directed vector table, corner-case sequences and
// randomized operations against an arithmetic reference model.
module tb_peripheral_opcalc;

    localparam int WIDTH = 32;
    localparam int OPW   = 4;
    localparam int NVEC  = 17;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [OPW-1:0]   opsel = '0;
    logic [WIDTH-1:0] dataA = '0;
    logic [WIDTH-1:0] dataB = '0;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             done;
    logic             error;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [OPW-1:0]   op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] res;
        logic             err;
        int               lat;
    } vec_t;

    vec_t tbl[NVEC];

    always #5 clk = ~clk;

    peripheral_opcalc #(
        .WIDTH(WIDTH),
        .OPW  (OPW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .opsel (opsel),
        .dataA (dataA),
        .dataB (dataB),
        .result(result),
        .busy  (busy),
        .done  (done),
        .error (error)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input int op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic [WIDTH-1:0] res, input logic err, input int lat);
        vec_t v;
        v.op = OPW'(op); v.a = a; v.b = b; v.res = res; v.err = err; v.lat = lat;
        return v;
    endfunction

    // Reference: what each opcode means arithmetically, and how long it takes.
    function automatic void model(input logic [OPW-1:0] op, input logic [WIDTH-1:0] a,
                                  input logic [WIDTH-1:0] b, output logic [WIDTH-1:0] r,
                                  output logic e, output int lat);
        logic [63:0] p;
        e = 1'b0; lat = 2; r = '0;
        case (op)
            0: r = a + b;
            1: r = a - b;
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; lat = WIDTH + 1; end
            6: if (b == 0) begin r = '1; e = 1'b1; end else begin r = a / b; lat = WIDTH + 1; end
            7: if (b == 0) begin r = a; e = 1'b1; end else begin r = a % b; lat = WIDTH + 1; end
            default: begin r = '0; e = 1'b1; end
        endcase
    endfunction

    // Issues one operation, scrambles the inputs after capture, returns at the done cycle.
    task automatic run_check(input string name, input logic [OPW-1:0] op, input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp_res,
                             input logic exp_err, input int exp_lat);
        int lat;
        int nbusy;
        @(negedge clk);
        start = 1'b1; opsel = op; dataA = a; dataB = b;
        @(negedge clk);
        start = 1'b0; opsel = OPW'($urandom); dataA = $urandom; dataB = $urandom;
        lat = 1; nbusy = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) nbusy++;
            @(negedge clk);
            lat++;
        end
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        check({name, " result"}, 64'(result), 64'(exp_res));
        check({name, " error"}, 64'(error), 64'(exp_err));
        check({name, " busy cycles"}, 64'(nbusy), 64'(exp_lat - 1));
        check({name, " busy at done"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] r_exp;
        logic             e_exp;
        int               l_exp;
        logic [OPW-1:0]   op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        int               ndone;
        int               lat_seen;
        logic [WIDTH-1:0] res_seen;

        tbl[0]  = mk(0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 2);
        tbl[1]  = mk(5, 32'd1234, 32'd5678, 32'd7006652, 1'b0, 33);
        tbl[2]  = mk(6, 32'd100, 32'd7, 32'd14, 1'b0, 33);
        tbl[3]  = mk(7, 32'd100, 32'd7, 32'd2, 1'b0, 33);
        tbl[4]  = mk(6, 32'd55, 32'd0, 32'hFFFF_FFFF, 1'b1, 2);
        tbl[5]  = mk(0, 32'd3, 32'd4, 32'd7, 1'b0, 2);
        tbl[6]  = mk(1, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 2);
        tbl[7]  = mk(2, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0, 2);
        tbl[8]  = mk(3, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFFF0_FFFF, 1'b0, 2);
        tbl[9]  = mk(4, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB, 1'b0, 2);
        tbl[10] = mk(7, 32'd55, 32'd0, 32'd55, 1'b1, 2);
        tbl[11] = mk(9, 32'd12, 32'd34, 32'd0, 1'b1, 2);
        tbl[12] = mk(5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0, 33);
        tbl[13] = mk(6, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, 33);
        tbl[14] = mk(0, 32'd10, 32'd20, 32'd30, 1'b0, 2);
        tbl[15] = mk(7, 32'd7, 32'd100, 32'd7, 1'b0, 33);
        tbl[16] = mk(6, 32'd5, 32'd9, 32'd0, 1'b0, 33);

        // Power-on reset
        #3 reset = 1'b0;
        #1;
        check("reset result", 64'(result), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset error", 64'(error), 64'd0);
        repeat (3) @(negedge clk);
        check("reset held result", 64'(result), 64'd0);
        reset = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            run_check($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
                      tbl[i].res, tbl[i].err, tbl[i].lat);
        end

        // start asserted only during DONE must be ignored
        run_check("pre-done-ignore", OPW'(0), 32'd1, 32'd1, 32'd2, 1'b0, 2);
        start = 1'b1; opsel = OPW'(5); dataA = 32'd3; dataB = 32'd3;
        @(negedge clk);
        start = 1'b0;
        check("start in DONE busy", 64'(busy), 64'd0);
        @(negedge clk);
        check("start in DONE busy2", 64'(busy), 64'd0);
        check("start in DONE result", 64'(result), 64'd2);

        // Start every cycle during a MUL with changing operands
        @(negedge clk);
        start = 1'b1; opsel = OPW'(5); dataA = 32'd1234; dataB = 32'd5678;
        ndone = 0; lat_seen = 0; res_seen = '0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ndone++;
                if (ndone == 1) begin
                    lat_seen = c;
                    res_seen = result;
                end
                start = 1'b0;
            end else if (ndone == 0) begin
                start = 1'b1; opsel = OPW'($urandom_range(0, 9));
                dataA = $urandom; dataB = $urandom;
            end
        end
        check("spam done count", 64'(ndone), 64'd1);
        check("spam latency", 64'(lat_seen), 64'(WIDTH + 1));
        check("spam result", 64'(res_seen), 64'd7006652);
        check("spam idle after", 64'(busy), 64'd0);

        // Reset in the middle of a DIV
        run_check("pre-reset div0", OPW'(6), 32'd55, 32'd0, 32'hFFFF_FFFF, 1'b1, 2);
        @(negedge clk);
        start = 1'b1; opsel = OPW'(6); dataA = 32'd1000; dataB = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("mid-div busy", 64'(busy), 64'd1);
        #2 reset = 1'b0;
        #1;
        check("mid-div reset result", 64'(result), 64'd0);
        check("mid-div reset busy", 64'(busy), 64'd0);
        check("mid-div reset error", 64'(error), 64'd0);
        check("mid-div reset done", 64'(done), 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("aborted div no done", 64'(ndone), 64'd0);
        run_check("post-reset sub", OPW'(1), 32'd9, 32'd4, 32'd5, 1'b0, 2);

        // Randomized operations against the reference model
        for (int i = 0; i < 150; i++) begin
            op = OPW'($urandom_range(0, 9));
            a  = $urandom >> $urandom_range(0, 31);
            b  = ($urandom_range(0, 7) == 0) ? '0 : ($urandom >> $urandom_range(0, 31));
            model(op, a, b, r_exp, e_exp, l_exp);
            run_check($sformatf("rand%0d op%0d", i, op), op, a, b, r_exp, e_exp, l_exp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/peripheral_opcalc.md
PERIPHERAL_OPCALC -- requirements
Module: peripheral_opcalc

Interface
REQ-001 Parameter: WIDTH, default 32, operand and result width in bits.
REQ-002 Parameter: OPW, default 3, opcode width in bits.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 start  input  1  one-cycle request pulse; sampled only in IDLE.
REQ-006 opsel  input  OPW  operation select; captured with start.
REQ-007 dataA  input  WIDTH  operand A, driven by the get-operands stage; captured with start.
REQ-008 dataB  input  WIDTH  operand B, driven by the get-operands stage; captured with start.
REQ-009 result  output  WIDTH  registered result; holds its value between operations.
REQ-010 busy  output  1  high from the cycle after start is accepted until done is asserted.
REQ-011 done  output  1  one-cycle completion strobe.
REQ-012 error  output  1  registered status for the last operation (divide by zero or illegal opcode).

Function
REQ-013 Opcodes: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 MUL (low WIDTH bits, unsigned), 6 DIV (unsigned quotient), 7 REM (unsigned remainder).
REQ-014 FSM states: IDLE, CALC, ITER, DONE.
REQ-015 IDLE with start=1: capture opsel/dataA/dataB; next state is ITER for MUL, or for DIV/REM with B!=0; next state is CALC for all other cases.
REQ-016 CALC: compute in one cycle, then register result and error; next state DONE.
REQ-017 ITER: one shift-add (MUL) or restoring-subtract (DIV/REM) step per cycle.
REQ-018 ITER runs for exactly WIDTH cycles, counted by a $clog2(WIDTH)+1-bit counter; next state DONE.
REQ-019 DONE: done=1 for exactly one cycle, busy=0; next state IDLE.
REQ-020 Latency for ADD/SUB/logic ops, illegal opcodes, and DIV/REM with B=0: done high in the 2nd cycle after the start-sampling edge.
REQ-021 Latency for MUL/DIV/REM: done high in cycle WIDTH+1 after the start-sampling edge.
REQ-022 Back-to-back operation: a start pulse in the first IDLE cycle after DONE is accepted.
REQ-023 ADD/SUB wrap modulo 2^WIDTH; no carry or overflow output.
REQ-024 MUL discards bits [2*WIDTH-1:WIDTH] of the product.
REQ-025 DIV/REM with B=0: result = all ones (DIV) or A (REM), error=1.
REQ-026 Opcodes outside 0..7 (only possible when OPW>3): result=0, error=1.
REQ-027 error is cleared to 0 on every operation completing without fault.
REQ-028 start while busy, or while in DONE, is ignored; the in-flight operation completes with its captured operands.
REQ-029 Changes on dataA/dataB/opsel after capture have no effect on the in-flight operation.
REQ-030 result and error update only on the edge entering DONE; done and busy are registered, glitch-free outputs.

Reset
REQ-031 reset=0 forces immediately: state IDLE, result=0, busy=0, done=0, error=0, iteration counter=0, captured operands=0.
REQ-032 Reset asserted mid-ITER aborts the operation; no done is produced for it.
REQ-033 After reset release, the first start is accepted normally.

Structure
REQ-034 Shared package peripheral_pkg holds the opcode enum, the FSM state enum, and default WIDTH/OPW constants.
REQ-035 The iterative datapath (multiplicand/partial-product and divisor/remainder registers, step logic) lives in sub-module peripheral_muldiv_iter.
REQ-036 peripheral_muldiv_iter interface: load, step, mode, a, b, product, quotient, remainder.
REQ-037 FSM, counter, single-cycle ALU and output registers live in peripheral_opcalc.

Verification
REQ-038 ADD: A=32'hFFFF_FFFF, B=1, op=0 -> 2 cycles later done=1, result=0, error=0.
REQ-039 MUL: A=1234, B=5678 -> done exactly 33 cycles after start, result=7006652, busy high for the 32 intervening cycles.
REQ-040 DIV/REM: A=100, B=7 -> op=6 gives result=14; op=7 gives result=2; both with 33-cycle latency.
REQ-041 Divide by zero: A=55, B=0, op=6 -> 2-cycle latency, result=32'hFFFF_FFFF, error=1.
REQ-042 Divide by zero followed by ADD 3+4 -> result=7, error=0.
REQ-043 Start pulses every cycle during a MUL, with dataA changing each cycle -> single done, result from the originally captured operands, extra starts ignored.
REQ-044 reset=0 at iteration 10 of DIV -> outputs zero immediately, no done; a fresh SUB 9-4 afterwards yields result=5.
